// File: rtl/stopwatch_pkg.sv
// Shared definitions for the stopwatch controller: state encoding,
// BCD digit width and the default tens-digit limits.
package stopwatch_pkg;

    localparam int DIGIT_W          = 4;
    localparam int SEC_TENS_MAX_DEF = 5;
    localparam int MIN_TENS_MAX_DEF = 5;

    typedef enum logic [1:0] {
        ST_STOP = 2'd0,
        ST_RUN  = 2'd1,
        ST_ADJ  = 2'd2
    } sw_state_t;

endpackage

// File: rtl/stopwatch_ctrl_bcd_mod60_counter.sv
// Two-digit BCD counter (tens:ones) wrapping at tens_max:9 back to 00.
// A tens digit found above tens_max is treated as "at max" so the next
// increment pulls it back into the legal range.
module bcd_mod60_counter
    import stopwatch_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic               clr,
    input  logic               inc,
    input  logic [DIGIT_W-1:0] tens_max,
    output logic [DIGIT_W-1:0] tens,
    output logic [DIGIT_W-1:0] ones,
    output logic               carry
);

    logic ones_at_max;
    logic tens_at_max;

    assign ones_at_max = (ones >= DIGIT_W'(9));
    assign tens_at_max = (tens >= tens_max);
    assign carry       = inc & ones_at_max & tens_at_max;

    // Digit registers: clear wins over increment.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            tens <= '0;
            ones <= '0;
        end else if (clr) begin
            tens <= '0;
            ones <= '0;
        end else if (inc) begin
            if (ones_at_max) begin
                ones <= '0;
                tens <= tens_at_max ? '0 : tens + DIGIT_W'(1);
            end else begin
                ones <= ones + DIGIT_W'(1);
            end
        end
    end

endmodule

// File: rtl/stopwatch_ctrl.sv
// Stopwatch sequencer: run/stop/adjust modes, MM:SS BCD time, and
// per-field blanking for the display multiplexer.
//
//   state   | meaning
//   --------+-----------------------------------------------------
//   ST_STOP | time held, all ticks ignored
//   ST_RUN  | count_tick advances MM:SS with carry seconds->minutes
//   ST_ADJ  | adj_tick advances the field picked by sel_sw, blink on
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int SEC_TENS_MAX = SEC_TENS_MAX_DEF,
    parameter int MIN_TENS_MAX = MIN_TENS_MAX_DEF
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               count_tick,
    input  logic               adj_tick,
    input  logic               blink_tick,
    input  logic               pause_btn,
    input  logic               reset_btn,
    input  logic               adj_sw,
    input  logic               sel_sw,
    output logic [DIGIT_W-1:0] min_tens,
    output logic [DIGIT_W-1:0] min_ones,
    output logic [DIGIT_W-1:0] sec_tens,
    output logic [DIGIT_W-1:0] sec_ones,
    output logic               running,
    output logic               blank_min,
    output logic               blank_sec
);

    localparam logic [DIGIT_W-1:0] SEC_MAX = DIGIT_W'(SEC_TENS_MAX);
    localparam logic [DIGIT_W-1:0] MIN_MAX = DIGIT_W'(MIN_TENS_MAX);

    sw_state_t state;
    sw_state_t state_next;
    logic      pause_prev;
    logic      reset_prev;
    logic      pause_edge;
    logic      reset_edge;
    logic      phase;
    logic      phase_next;
    logic      count_en;
    logic      sec_inc;
    logic      min_adj_inc;
    logic      min_inc;
    logic      sec_carry;
    logic      min_carry_unused;

    assign pause_edge = pause_btn & ~pause_prev;
    assign reset_edge = reset_btn & ~reset_prev;

    // In run mode minutes follow the seconds carry; in adjust they are
    // stepped directly and the seconds carry is deliberately dropped.
    assign min_inc = count_en ? sec_carry : min_adj_inc;

    // Button history flops for rising-edge detection.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            pause_prev <= 1'b0;
            reset_prev <= 1'b0;
        end else begin
            pause_prev <= pause_btn;
            reset_prev <= reset_btn;
        end
    end

    // State, blink phase and registered display flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= ST_STOP;
            phase     <= 1'b0;
            blank_min <= 1'b0;
            blank_sec <= 1'b0;
        end else begin
            state     <= state_next;
            phase     <= phase_next;
            blank_min <= (state_next == ST_ADJ) & ~sel_sw & phase_next;
            blank_sec <= (state_next == ST_ADJ) &  sel_sw & phase_next;
        end
    end

    assign running = (state == ST_RUN);

    // Next state and counter enables; reset edge beats adjust beats run/pause.
    always_comb begin
        state_next  = state;
        phase_next  = 1'b0;
        count_en    = 1'b0;
        sec_inc     = 1'b0;
        min_adj_inc = 1'b0;
        if (reset_edge) begin
            state_next = adj_sw ? ST_ADJ : ST_STOP;
            phase_next = (state == ST_ADJ) & adj_sw & phase;
        end else if (adj_sw) begin
            state_next = ST_ADJ;
            if (state == ST_ADJ) begin
                sec_inc     = adj_tick & sel_sw;
                min_adj_inc = adj_tick & ~sel_sw;
                phase_next  = phase ^ blink_tick;
            end
        end else begin
            unique case (state)
                ST_STOP: begin
                    if (pause_edge) state_next = ST_RUN;
                end
                ST_RUN: begin
                    count_en = 1'b1;
                    sec_inc  = count_tick;
                    if (pause_edge) state_next = ST_STOP;
                end
                ST_ADJ:  state_next = ST_STOP;
                default: state_next = ST_STOP;
            endcase
        end
    end

    bcd_mod60_counter u_sec (
        .clk      (clk),
        .rst      (rst),
        .clr      (reset_edge),
        .inc      (sec_inc),
        .tens_max (SEC_MAX),
        .tens     (sec_tens),
        .ones     (sec_ones),
        .carry    (sec_carry)
    );

    bcd_mod60_counter u_min (
        .clk      (clk),
        .rst      (rst),
        .clr      (reset_edge),
        .inc      (min_inc),
        .tens_max (MIN_MAX),
        .tens     (min_tens),
        .ones     (min_ones),
        .carry    (min_carry_unused)
    );

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Self-checking bench for stopwatch_ctrl: directed scenarios plus a
// randomized run compared against a seconds-based reference model.
module tb_stopwatch_ctrl;

    localparam int M_STOP = 0;
    localparam int M_RUN  = 1;
    localparam int M_ADJ  = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       count_tick, adj_tick, blink_tick;
    logic       pause_btn, reset_btn, adj_sw, sel_sw;
    logic [3:0] min_tens, min_ones, sec_tens, sec_ones;
    logic       running, blank_min, blank_sec;

    int n_checks = 0;
    int n_fail   = 0;

    // Reference model: total elapsed seconds plus mode and blink phase.
    int m_t;
    int m_mode;
    bit m_phase, m_pprev, m_rprev, m_bmin, m_bsec;

    stopwatch_ctrl dut (
        .clk        (clk),
        .rst        (rst),
        .count_tick (count_tick),
        .adj_tick   (adj_tick),
        .blink_tick (blink_tick),
        .pause_btn  (pause_btn),
        .reset_btn  (reset_btn),
        .adj_sw     (adj_sw),
        .sel_sw     (sel_sw),
        .min_tens   (min_tens),
        .min_ones   (min_ones),
        .sec_tens   (sec_tens),
        .sec_ones   (sec_ones),
        .running    (running),
        .blank_min  (blank_min),
        .blank_sec  (blank_sec)
    );

    always #5 clk = ~clk;

    function automatic logic [18:0] mk(input int mm, input int ss, input bit run,
                                       input bit bm, input bit bs);
        return {4'(mm / 10), 4'(mm % 10), 4'(ss / 10), 4'(ss % 10), run, bm, bs};
    endfunction

    function automatic logic [18:0] obs();
        return {min_tens, min_ones, sec_tens, sec_ones, running, blank_min, blank_sec};
    endfunction

    function automatic logic [18:0] model_vec();
        return mk(m_t / 60, m_t % 60, m_mode == M_RUN, m_bmin, m_bsec);
    endfunction

    task automatic model_reset();
        m_t = 0; m_mode = M_STOP; m_phase = 0;
        m_pprev = 0; m_rprev = 0; m_bmin = 0; m_bsec = 0;
    endtask

    task automatic model_step(input bit c, input bit a, input bit b, input bit p,
                              input bit r, input bit aw, input bit sw);
        bit pe, re;
        int mm, ss;
        pe = p && !m_pprev;
        re = r && !m_rprev;
        m_pprev = p;
        m_rprev = r;
        mm = m_t / 60;
        ss = m_t % 60;
        if (re) begin
            m_t = 0;
            m_mode = aw ? M_ADJ : M_STOP;
            if (m_mode != M_ADJ) m_phase = 0;
        end else if (aw) begin
            if (m_mode == M_ADJ) begin
                if (a) begin
                    if (sw) ss = (ss + 1) % 60;
                    else    mm = (mm + 1) % 60;
                end
                m_t = mm * 60 + ss;
                if (b) m_phase = !m_phase;
            end
            m_mode = M_ADJ;
        end else begin
            if (m_mode == M_STOP) begin
                if (pe) m_mode = M_RUN;
            end else if (m_mode == M_RUN) begin
                if (c) m_t = (m_t + 1) % 3600;
                if (pe) m_mode = M_STOP;
            end else begin
                m_mode = M_STOP;
            end
            m_phase = 0;
        end
        m_bmin = (m_mode == M_ADJ) && !sw && m_phase;
        m_bsec = (m_mode == M_ADJ) &&  sw && m_phase;
    endtask

    task automatic step(input bit c, input bit a, input bit b, input bit p,
                        input bit r, input bit aw, input bit sw);
        @(negedge clk);
        count_tick = c; adj_tick = a; blink_tick = b;
        pause_btn = p; reset_btn = r; adj_sw = aw; sel_sw = sw;
        @(posedge clk);
        model_step(c, a, b, p, r, aw, sw);
        #1;
    endtask

    task automatic idle(input int n);
        repeat (n) step(0, 0, 0, 0, 0, 0, 0);
    endtask

    // Loads MM:SS through adjust mode and leaves adjust (stopped).
    task automatic set_time(input int mm, input int ss);
        int n;
        step(0, 0, 0, 0, 0, 1, 0);
        n = (mm - m_t / 60 + 60) % 60;
        repeat (n) step(0, 1, 0, 0, 0, 1, 0);
        n = (ss - m_t % 60 + 60) % 60;
        repeat (n) step(0, 1, 0, 0, 0, 1, 1);
        step(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic test_reset();
        #3;
        n_checks++;
        if (obs() !== mk(0, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL reset_state: got %h want %h", obs(), mk(0, 0, 0, 0, 0));
        end
        #9 rst = 1'b1;
        set_time(12, 34);
        step(0, 0, 0, 1, 0, 0, 0);
        idle(3);
        n_checks++;
        if (obs() !== mk(12, 34, 1, 0, 0)) begin
            n_fail++;
            $display("FAIL preload_12_34: got %h want %h", obs(), mk(12, 34, 1, 0, 0));
        end
        #1 rst = 1'b0;
        #1;
        n_checks++;
        if (obs() !== mk(0, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL async_reset: got %h want %h", obs(), mk(0, 0, 0, 0, 0));
        end
        model_reset();
        #1 rst = 1'b1;
    endtask

    task automatic test_run_count();
        step(0, 0, 0, 1, 0, 0, 0);
        repeat (61) step(1, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (obs() !== mk(1, 1, 1, 0, 0)) begin
            n_fail++;
            $display("FAIL run_61_ticks: got %h want %h", obs(), mk(1, 1, 1, 0, 0));
        end
        step(0, 0, 0, 1, 0, 0, 0);
        repeat (5) step(1, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (obs() !== mk(1, 1, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL stopped_hold: got %h want %h", obs(), mk(1, 1, 0, 0, 0));
        end
    endtask

    task automatic test_wrap();
        set_time(59, 59);
        n_checks++;
        if (obs() !== mk(59, 59, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL preload_59_59: got %h want %h", obs(), mk(59, 59, 0, 0, 0));
        end
        step(0, 0, 0, 1, 0, 0, 0);
        step(1, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (obs() !== mk(0, 0, 1, 0, 0)) begin
            n_fail++;
            $display("FAIL wrap_59_59: got %h want %h", obs(), mk(0, 0, 1, 0, 0));
        end
        step(1, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (obs() !== mk(0, 1, 1, 0, 0)) begin
            n_fail++;
            $display("FAIL after_wrap: got %h want %h", obs(), mk(0, 1, 1, 0, 0));
        end
        step(0, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic test_adjust();
        set_time(0, 58);
        step(0, 0, 0, 0, 0, 1, 1);
        repeat (3) step(1, 1, 0, 0, 0, 1, 1);
        n_checks++;
        if (obs() !== mk(0, 1, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL adj_sec_wrap: got %h want %h", obs(), mk(0, 1, 0, 0, 0));
        end
        step(0, 0, 1, 0, 0, 1, 1);
        n_checks++;
        if (obs() !== mk(0, 1, 0, 0, 1)) begin
            n_fail++;
            $display("FAIL blink_sec_on: got %h want %h", obs(), mk(0, 1, 0, 0, 1));
        end
        step(1, 0, 1, 0, 0, 1, 1);
        n_checks++;
        if (obs() !== mk(0, 1, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL blink_sec_off: got %h want %h", obs(), mk(0, 1, 0, 0, 0));
        end
        step(0, 1, 1, 0, 0, 1, 0);
        n_checks++;
        if (obs() !== mk(1, 1, 0, 1, 0)) begin
            n_fail++;
            $display("FAIL blink_min_on: got %h want %h", obs(), mk(1, 1, 0, 1, 0));
        end
        step(0, 0, 0, 1, 0, 0, 0);
        n_checks++;
        if (obs() !== mk(1, 1, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL adj_exit_stop: got %h want %h", obs(), mk(1, 1, 0, 0, 0));
        end
    endtask

    task automatic test_reset_priority();
        set_time(0, 9);
        step(0, 0, 0, 1, 0, 0, 0);
        idle(2);
        step(1, 0, 0, 1, 1, 0, 0);
        n_checks++;
        if (obs() !== mk(0, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL reset_priority: got %h want %h", obs(), mk(0, 0, 0, 0, 0));
        end
        step(1, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (obs() !== mk(0, 0, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL reset_then_tick: got %h want %h", obs(), mk(0, 0, 0, 0, 0));
        end
    endtask

    task automatic test_pause_tick();
        set_time(0, 5);
        step(0, 0, 0, 1, 0, 0, 0);
        idle(1);
        step(1, 0, 0, 1, 0, 0, 0);
        n_checks++;
        if (obs() !== mk(0, 6, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL run_pause_tick: got %h want %h", obs(), mk(0, 6, 0, 0, 0));
        end
        step(1, 0, 0, 0, 0, 0, 0);
        n_checks++;
        if (obs() !== mk(0, 6, 0, 0, 0)) begin
            n_fail++;
            $display("FAIL tick_after_stop: got %h want %h", obs(), mk(0, 6, 0, 0, 0));
        end
        step(1, 0, 0, 1, 0, 0, 0);
        n_checks++;
        if (obs() !== mk(0, 6, 1, 0, 0)) begin
            n_fail++;
            $display("FAIL stop_pause_tick: got %h want %h", obs(), mk(0, 6, 1, 0, 0));
        end
        step(0, 0, 0, 1, 0, 0, 0);
    endtask

    task automatic test_random();
        bit aw, sw;
        aw = 0;
        sw = 0;
        for (int i = 0; i < 1500; i++) begin
            if ($urandom_range(0, 39) == 0) aw = !aw;
            if ($urandom_range(0, 7) == 0)  sw = !sw;
            step($urandom_range(0, 2) == 0, $urandom_range(0, 2) == 0,
                 $urandom_range(0, 2) == 0, $urandom_range(0, 5) == 0,
                 $urandom_range(0, 59) == 0, aw, sw);
            n_checks++;
            if (obs() !== model_vec()) begin
                n_fail++;
                $display("FAIL random_cycle_%0d: got %h want %h", i, obs(), model_vec());
            end
        end
    endtask

    initial begin
        rst = 1'b0;
        count_tick = 0; adj_tick = 0; blink_tick = 0;
        pause_btn = 0; reset_btn = 0; adj_sw = 0; sel_sw = 0;
        model_reset();
        test_reset();
        test_run_count();
        test_wrap();
        test_adjust();
        test_reset_priority();
        test_pause_tick();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/stopwatch_ctrl.md
Name: stopwatch_ctrl

Overview:
- Sequences the stopwatch time counter using the single-cycle enable ticks from the clock divider.
- Owns the run, pause, reset and adjust modes, and holds the MM:SS value as four BCD digits.
- Drives per-field blanking for the display multiplexer.
- Sits between the debounced button/switch inputs and the 7-segment display scanner. Everything runs in the single `clk` domain.

Parameters:
- SEC_TENS_MAX, 5, max value of the seconds tens digit (seconds wrap at SEC_TENS_MAX·10+9).
- MIN_TENS_MAX, 5, max value of the minutes tens digit (minutes wrap likewise).

Ports:
- clk  in  1  system clock, 100 MHz
- rst  in  1  asynchronous, active-low reset
- count_tick  in  1  one-cycle enable, 1 Hz; advances time while running
- adj_tick  in  1  one-cycle enable, 2 Hz; advances the selected field in adjust mode
- blink_tick  in  1  one-cycle enable, 4 Hz; toggles the blink phase
- pause_btn  in  1  debounced, synchronized level; rising edge toggles run/stop
- reset_btn  in  1  debounced, synchronized level; rising edge clears the time
- adj_sw  in  1  1 = adjust mode
- sel_sw  in  1  in adjust: 0 = minutes, 1 = seconds
- min_tens  out  4  BCD
- min_ones  out  4  BCD
- sec_tens  out  4  BCD
- sec_ones  out  4  BCD
- running  out  1  1 while in ST_RUN
- blank_min  out  1  display blanks the minute digits when 1
- blank_sec  out  1  display blanks the second digits when 1

Behaviour:
- **Reset** (rst=0, async): state=ST_STOP, all digits 0, running=0, blank_min=0, blank_sec=0, blink phase=0, edge-detect registers=0.
- **Edge detection:** each button has a 1-flop history; edge = level & ~prev. Button edges act one cycle after the level rises.
- **States:** ST_STOP, ST_RUN, ST_ADJ.
  - ST_STOP → ST_RUN on pause edge (adj_sw=0).
  - ST_RUN → ST_STOP on pause edge.
  - Any state → ST_ADJ when adj_sw=1; pause edges are ignored while adj_sw=1.
  - ST_ADJ → ST_STOP when adj_sw=0. Leaving adjust never resumes running.
- **Priority each cycle:** reset_btn edge > adjust > run/pause.
  - A reset edge clears all digits to 00:00, forces ST_STOP (or ST_ADJ if adj_sw=1), and discards any same-cycle tick or pause edge.
- **ST_RUN counting:** on count_tick, sec_ones++.
  - sec_ones 9 → 0 carries to sec_tens; sec_tens SEC_TENS_MAX with carry → 0 and increments minutes.
  - Minutes wrap the same way, so 59:59 → 00:00. No overflow flag.
- **ST_STOP:** digits hold; all ticks are ignored.
- **ST_ADJ:** count_tick is ignored.
  - On adj_tick, the field chosen by sel_sw increments by 1 mod 60.
  - Seconds wrap without carrying into minutes; minutes wrap independently.
  - sel_sw may change on any cycle; it is sampled in the same cycle as adj_tick.
- **Pause edge coinciding with count_tick:** the tick is applied according to the registered state, and the new state takes effect next cycle.
  - RUN + pause edge + tick → increments, then stops.
  - STOP + pause edge + tick → no increment.
- **Blink:** the blink phase toggles on blink_tick only in ST_ADJ and is forced to 0 on leaving ST_ADJ.
  - blank_min = ST_ADJ & ~sel_sw & phase.
  - blank_sec = ST_ADJ & sel_sw & phase.
- **Outputs:** all registered; running = (state==ST_RUN). No combinational path from inputs to outputs.
- **Digit invariant:** digits never leave the legal range. If a tens digit is somehow > its MAX, the next increment wraps it to 0.

Decomposition:
- Package stopwatch_pkg holds:
  - the state encoding (ST_STOP=2'd0, ST_RUN=2'd1, ST_ADJ=2'd2);
  - the BCD digit width (4);
  - the default tens limits.
- One sub-module, bcd_mod60_counter, is instantiated twice (seconds, minutes).
  - Ports: clk, rst, clr, inc, tens_max; outputs tens[3:0], ones[3:0], carry.
  - carry = inc & at max.
  - The top level gates the minutes inc with the seconds carry only in ST_RUN.

Test Plan:
- rst low mid-count at 12:34 → all digits 0, running=0, blanks 0 immediately (async), before any clk edge.
- Pause edge, then 61 count_ticks → 01:01, running=1; second pause edge, then 5 ticks → still 01:01, running=0.
- Preload 59:59 via adjust, run, 1 count_tick → 00:00 with no stray carry.
- adj_sw=1, sel_sw=1 at 00:58, 3 adj_ticks → 00:01 (minutes unchanged).
  - count_ticks ignored.
  - blank_sec toggles on each blink_tick; blank_min stays 0.
- Running at 00:09, with reset_btn edge, pause edge and count_tick in the same cycle → 00:00, ST_STOP, running=0.
- Running, pause edge coincident with count_tick at 00:05 → 00:06, then stopped; the next tick leaves 00:06.
